// File: rtl/lcd_line_doubler.sv
// lcd_line_doubler: buffers each input line in a ping-pong RAM and replays it twice at double pixel rate,
// or passes the input stream through one register stage when doubling is disabled.
module lcd_line_doubler #(
  parameter int MAX_H = 512,
  parameter int HS_OUT_W = 16
) (
  input  logic                   clk_vid,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   ce_pix,
  input  logic                   hs_in,
  input  logic                   vs_in,
  input  logic                   hbl_in,
  input  logic                   vbl_in,
  input  logic [7:0]             r_in,
  input  logic [7:0]             g_in,
  input  logic [7:0]             b_in,
  output logic                   ce_out,
  output logic                   hs_out,
  output logic                   vs_out,
  output logic                   hbl_out,
  output logic                   vbl_out,
  output logic [7:0]             r_out,
  output logic [7:0]             g_out,
  output logic [7:0]             b_out,
  output logic [$clog2(MAX_H):0] line_len,
  output logic                   overflow
);
  localparam int AW = $clog2(MAX_H);
  logic [AW:0] wr_x, rd_x, wx_e, x_e, len_e;
  logic [3:0] cnt;
  logic [4:0] per;
  logic wr_bank, pass, idle, mode_dbl, vs_line, hs_prev;
  logic ls, st, wb, wr_ok, idle_e, pass_e, dbl_e, vs_e, wrap;
  logic blank_q, byp_q, vbl_hold, hbl_b, vbl_b;
  logic [7:0] r_b, g_b, b_b;
  logic [25:0] ram [2**(AW+1)];
  logic [25:0] rd_q;
  assign ls = ce_pix & hs_in & ~hs_prev;
  assign st = ce_pix | ({1'b0, cnt} + 5'd1 == {1'b0, per[4:1]});
  // On a line start the new line's values take effect on the same strobe, so the first replayed
  // pixel is fetched from the just-completed bank while pixel 0 of the new line lands in the other.
  assign wb = wr_bank ^ ls;
  assign wx_e = ls ? '0 : wr_x;
  assign wr_ok = wx_e < (AW+1)'(MAX_H);
  assign x_e = ls ? '0 : rd_x;
  assign len_e = ls ? wr_x : line_len;
  assign idle_e = ls ? wr_x == '0 : idle;
  assign pass_e = ~ls & pass;
  assign dbl_e = ls ? enable : mode_dbl;
  assign vs_e = ls ? vs_in : vs_line;
  assign wrap = x_e == len_e - 1'b1;
  always_ff @(posedge clk_vid) begin
    if (ce_pix && wr_ok) ram[{wb, wx_e[AW-1:0]}] <= {hbl_in, vbl_in, r_in, g_in, b_in};
    if (st) rd_q <= ram[{~wb, x_e[AW-1:0]}];
  end
  always_ff @(posedge clk_vid or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      per <= 5'd10;
      hs_prev <= 1'b0;
      wr_x <= '0;
      overflow <= 1'b0;
      line_len <= '0;
      wr_bank <= 1'b0;
      mode_dbl <= 1'b1;
      vs_line <= 1'b0;
      rd_x <= '0;
      pass <= 1'b0;
      idle <= 1'b1;
      byp_q <= 1'b0;
      blank_q <= 1'b1;
      vbl_hold <= 1'b1;
      ce_out <= 1'b0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      {hbl_b, vbl_b, r_b, g_b, b_b} <= {2'b11, 24'd0};
    end else begin
      cnt <= ce_pix ? 4'd0 : cnt + {3'd0, ~&cnt};
      if (ce_pix) begin
        per <= {1'b0, cnt} + 5'd1;
        hs_prev <= hs_in;
        wr_x <= wr_ok ? wx_e + 1'b1 : wx_e;
        overflow <= overflow | ~wr_ok;
      end
      if (ls) begin
        line_len <= wr_x;
        wr_bank <= ~wr_bank;
        mode_dbl <= enable;
        vs_line <= vs_in;
      end
      if (st) begin
        rd_x <= (idle_e | wrap) ? '0 : x_e + 1'b1;
        pass <= pass_e | wrap;
        idle <= idle_e | (wrap & pass_e);
      end
      byp_q <= ~dbl_e;
      vbl_hold <= vbl_out;
      if (dbl_e) begin
        ce_out <= st;
        if (st) begin
          hs_out <= ~idle_e & (x_e < (AW+1)'(HS_OUT_W));
          vs_out <= vs_e;
          blank_q <= idle_e;
        end
      end else begin
        ce_out <= ce_pix;
        hs_out <= hs_in;
        vs_out <= vs_in;
        {hbl_b, vbl_b, r_b, g_b, b_b} <= {hbl_in, vbl_in, r_in, g_in, b_in};
      end
    end
  // Idle strobes keep the last vertical blank level while forcing the line blank.
  assign hbl_out = byp_q ? hbl_b : blank_q | rd_q[25];
  assign vbl_out = byp_q ? vbl_b : blank_q ? vbl_hold : rd_q[24];
  assign {r_out, g_out, b_out} = byp_q ? {r_b, g_b, b_b} : blank_q ? 24'd0 : rd_q[23:0];
endmodule

// File: tb/tb_lcd_line_doubler.sv
// tb_lcd_line_doubler: random video lines checked cycle by cycle against a strobe-indexed line model.
module tb_lcd_line_doubler;
  logic clk_vid = 0, reset_n = 1, enable = 1, ce_pix = 0;
  logic hs_in = 0, vs_in = 0, hbl_in = 0, vbl_in = 0;
  logic [7:0] r_in = 0, g_in = 0, b_in = 0;
  logic ce_out, hs_out, vs_out, hbl_out, vbl_out, overflow;
  logic [7:0] r_out, g_out, b_out;
  logic [9:0] line_len;
  int errors = 0, checks = 0;
  always #5 clk_vid = ~clk_vid;
  lcd_line_doubler dut (
    .clk_vid(clk_vid), .reset_n(reset_n), .enable(enable), .ce_pix(ce_pix),
    .hs_in(hs_in), .vs_in(vs_in), .hbl_in(hbl_in), .vbl_in(vbl_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .ce_out(ce_out), .hs_out(hs_out), .vs_out(vs_out), .hbl_out(hbl_out), .vbl_out(vbl_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .line_len(line_len), .overflow(overflow)
  );
  // model: lines as pixel arrays, output position as strobe count since the last line start
  logic [25:0] cur [512];
  logic [25:0] prv [512];
  int n_cur, prv_len, k, t, t_last, per;
  bit hs_prev, ovf, mode, vsl;
  logic e_ce, e_hs, e_vs, e_hbl, e_vbl;
  logic [23:0] e_rgb;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic mreset();
    t_last = t; per = 10; n_cur = 0; prv_len = 0; k = 0;
    hs_prev = 0; ovf = 0; mode = 1; vsl = 0;
    e_ce = 0; e_hs = 0; e_vs = 0; e_hbl = 1; e_vbl = 1; e_rgb = 0;
  endtask
  task automatic step();
    int el;
    bit st, ls;
    t++;
    el = t - t_last;
    st = ce_pix || el == per / 2;
    ls = ce_pix && hs_in && !hs_prev;
    if (ls) begin
      prv = cur; prv_len = n_cur; n_cur = 0; mode = enable; vsl = vs_in; k = 0;
    end
    if (ce_pix) begin
      if (n_cur < 512) begin
        cur[n_cur] = {hbl_in, vbl_in, r_in, g_in, b_in};
        n_cur++;
      end else ovf = 1;
      hs_prev = hs_in; per = el > 16 ? 16 : el; t_last = t;
    end
    if (!mode) begin
      e_ce = ce_pix; e_hs = hs_in; e_vs = vs_in; e_hbl = hbl_in; e_vbl = vbl_in; e_rgb = {r_in, g_in, b_in};
    end else begin
      e_ce = st;
      if (st) begin
        e_vs = vsl;
        if (k < 2 * prv_len) begin
          {e_hbl, e_vbl, e_rgb} = prv[k % prv_len];
          e_hs = k % prv_len < 16;
        end else begin
          e_hbl = 1; e_rgb = 0; e_hs = 0;
        end
        k++;
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk_vid);
    if (reset_n) step();
    else begin
      t++;
      mreset();
    end
    @(negedge clk_vid);
    check("ce_out", 32'(ce_out), 32'(e_ce));
    check("video", 32'({hs_out, vs_out, hbl_out, vbl_out, r_out, g_out, b_out}),
          32'({e_hs, e_vs, e_hbl, e_vbl, e_rgb}));
    check("status", 32'({overflow, line_len}), 32'({ovf, 10'(prv_len)}));
  endtask
  task automatic do_reset();
    reset_n = 0;
    #1;
    mreset();
    check("rst_out", 32'({ce_out, hs_out, vs_out, hbl_out, vbl_out, r_out, g_out, b_out}), 32'({5'b00011, 24'd0}));
    check("rst_stat", 32'({overflow, line_len}), 32'd0);
    ce_pix = 0;
    repeat (3) cyc();
    reset_n = 1;
  endtask
  // p == 0 draws a random period per pixel; pl is the gap after the last pixel
  task automatic line(input int n, input int p, input int pl, input int tog = -1,
                      input int rst_at = -1, input int gap_at = -1);
    bit vb;
    int gap;
    vb = 1'($urandom);
    for (int x = 0; x < n; x++) begin
      if (x == tog) enable = ~enable;
      if (x == rst_at) do_reset();
      ce_pix = 1; hs_in = x < 2; vs_in = vb; vbl_in = vb; hbl_in = x >= n - 4;
      r_in = 8'(x); g_in = 8'($urandom); b_in = 8'($urandom);
      cyc();
      gap = x == n - 1 ? pl : x == gap_at ? 2 : p == 0 ? int'($urandom_range(3, 16)) : p;
      for (int i = 1; i < gap; i++) begin
        ce_pix = 0; r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
        cyc();
      end
    end
  endtask
  initial begin
    t = 0;
    #2 reset_n = 0;
    #1 mreset();
    check("rst_init", 32'({ce_out, hs_out, vs_out, hbl_out, vbl_out, r_out, g_out, b_out}), 32'({5'b00011, 24'd0}));
    check("rst_len", 32'({overflow, line_len}), 32'd0);
    repeat (3) cyc();
    reset_n = 1;
    repeat (3) line(425, 10, 10);
    check("len425", 32'(line_len), 32'd425);
    repeat (2) line(354, 12, 16);
    check("len354", 32'(line_len), 32'd354);
    line(600, 4, 4);
    line(100, 6, 6);
    check("len_sat", 32'(line_len), 32'd512);
    check("ovf_set", 32'(overflow), 32'd1);
    line(40, 6, 6);
    check("ovf_sticky", 32'({overflow, line_len}), 32'({1'b1, 10'd100}));
    line(20, 6, 6);
    line(20, 6, 6, -1, -1, 5);
    line(20, 6, 6);
    line(11, 6, 6);
    line(5, 6, 6);
    line(11, 6, 6);
    line(300, 8, 8, 150);
    line(300, 8, 8);
    check("byp_en", 32'(enable), 32'd0);
    line(200, 8, 8, 100);
    line(200, 8, 8);
    line(425, 10, 10, -1, 200);
    check("ovf_clr", 32'(overflow), 32'd0);
    line(425, 10, 10);
    line(425, 10, 10);
    check("len_rst", 32'(line_len), 32'd425);
    repeat (4) line($urandom_range(30, 200), 0, $urandom_range(3, 16));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
